instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, address tagged on the first emitted instruction after reset.
REQ-002 Parameter NOP_WORD, 32'h0000_0013, word emitted in place of any instruction whose immediate is not encodable.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  request beat present.
REQ-006 ready_o  output  1  encoder accepts a beat this cycle.
REQ-007 fmt_i  input  3  format select, fmt_e: I_CALC, I_LOAD, S, B, U_LUI, U_AUIPC, JAL, JALR.
REQ-008 rd_i, rs1_i, rs2_i  input  5 each  register fields.
REQ-009 funct3_i  input  3 / funct7_i  input  7  function fields; funct7_i used only by I_CALC shifts (funct3 001/101).
REQ-010 imm_i  input  32  full-width signed (or U-upper) immediate value.
REQ-011 valid_o  output  1  encoded beat present.
REQ-012 ready_i  input  1  downstream accepts beat.
REQ-013 instr_o  output  32  encoded RV32I instruction word.
REQ-014 addr_o  output  32  byte address of the instr_o beat.
REQ-015 err_o  output  1  current beat's immediate was not encodable; instr_o = NOP_WORD.
REQ-016 err_cnt_o  output  16  saturating count of error beats delivered.

Function
REQ-017 Input accepted when valid_i && ready_o; output delivered when valid_o && ready_i.
REQ-018 One registered output stage; latency exactly 1 cycle from acceptance to valid_o.
REQ-019 ready_o = !valid_o || ready_i (same-cycle accept and deliver allowed; full throughput).
REQ-020 While valid_o && !ready_i, instr_o, addr_o and err_o held stable.
REQ-021 Opcodes: I_CALC 0010011, I_LOAD 0000011, S 0100011, B 1100011, U_LUI 0110111, U_AUIPC 0010111, JAL 1101111, JALR 1100111.
REQ-022 I/JALR: imm[11:0] to bits 31:20; shift forms: bits 31:25 = funct7_i, 24:20 = imm[4:0]; legal iff imm_i in [-2048, 2047] (shift: 0..31).
REQ-023 S: imm[11:5] to 31:25, imm[4:0] to 11:7; legal iff in [-2048, 2047].
REQ-024 B: imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11]; legal iff even and in [-4096, 4094].
REQ-025 U: imm[31:12] to 31:12; legal iff imm_i[11:0] == 0.
REQ-026 JAL: imm[20],imm[10:1],imm[11],imm[19:12]; legal iff even and in [-1048576, 1048574].
REQ-027 Unused fields per format driven to zero (e.g. rd for S/B, rs1/rs2 for U/JAL).
REQ-028 addr_o of first delivered beat = BASE_ADDR; increments by 4 after each delivery; wraps 32'hFFFF_FFFC -> 0.
REQ-029 err_cnt_o increments on delivery of a beat with err_o=1; saturates at 16'hFFFF.
REQ-030 Illegal fmt_i codes impossible (8 codes all defined).

Reset
REQ-031 rst_i high at a clock edge: valid_o=0, instr_o=0, err_o=0, addr_o=BASE_ADDR, err_cnt_o=0, ready_o=1 next cycle.
REQ-032 Reset mid-operation discards any held beat; no delivery occurs in the reset cycle.
REQ-033 Inputs during reset cycle are ignored.

Structure
REQ-034 Package enc_pkg holds fmt_e, the eight opcode constants and NOP_WORD default.
REQ-035 Combinational sub-module imm_pack (fmt, imm -> placed imm bits, legal flag); instr_encoder owns handshake, address and counter registers.

Verification
REQ-036 I_CALC ADDI rd=1 rs1=0 f3=0 imm=5 -> instr_o 32'h0050_0093, err_o=0, addr_o=BASE_ADDR.
REQ-037 B imm=-4 rs1=1 rs2=2 f3=1 -> 32'hFE20_9EE3; B imm=3 -> NOP_WORD, err_o=1, err_cnt_o=1.
REQ-038 Back-to-back 4 beats with ready_i stuck low 3 cycles after beat 1 -> instr_o stable, ready_o=0, addresses 0,4,8,12, no loss/duplication.
REQ-039 JAL rd=1 imm=2048 -> 32'h0010_00EF; U_LUI imm=32'h1234_5001 -> NOP_WORD, err_o=1.
REQ-040 Random legal beats over all formats -> decoding instr_o with the project immediate generator returns imm_i exactly.
REQ-041 rst_i asserted while valid_o && !ready_i -> next cycle valid_o=0, addr_o=BASE_ADDR, err_cnt_o=0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package enc_pkg;

    typedef enum logic [2:0] {
        I_CALC  = 3'd0,
        I_LOAD  = 3'd1,
        S       = 3'd2,
        B       = 3'd3,
        U_LUI   = 3'd4,
        U_AUIPC = 3'd5,
        JAL     = 3'd6,
        JALR    = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_I_CALC  = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S       = 7'b0100011;
    localparam logic [6:0] OP_B       = 7'b1100011;
    localparam logic [6:0] OP_U_LUI   = 7'b0110111;
    localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;

    // addi x0, x0, 0
    localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0013;

    // One registered output beat
    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } enc_beat_t;

    function automatic logic [6:0] opcode_of(fmt_e f);
        case (f)
            I_CALC:  return OP_I_CALC;
            I_LOAD:  return OP_I_LOAD;
            S:       return OP_S;
            B:       return OP_B;
            U_LUI:   return OP_U_LUI;
            U_AUIPC: return OP_U_AUIPC;
            JAL:     return OP_JAL;
            default: return OP_JALR;
        endcase
    endfunction

    // Signed range test on a full-width immediate
    function automatic logic in_range(logic [31:0] v, int lo, int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle for the instruction encoder.
interface instr_encoder_if;
    import enc_pkg::*;

    logic        valid_i;
    logic        ready_o;
    fmt_e        fmt_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        err_o;
    logic [15:0] err_cnt_o;

    modport slave (
        input  valid_i, fmt_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, ready_i,
        output ready_o, valid_o, instr_o, addr_o, err_o, err_cnt_o
    );

    modport master (
        output valid_i, fmt_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, ready_i,
        input  ready_o, valid_o, instr_o, addr_o, err_o, err_cnt_o
    );

endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Places immediate bits into their instruction positions and flags
// immediates that the selected format cannot represent.
module imm_pack
    import enc_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        legal
);

    logic shift_form;
    assign shift_form = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Scatter immediate bits per format; every non-immediate field stays zero
    always_comb begin
        imm_bits = '0;
        legal    = 1'b0;
        case (fmt)
            I_CALC: begin
                if (shift_form) begin
                    // shamt form: funct7 rides in the upper immediate slot
                    imm_bits[31:25] = funct7;
                    imm_bits[24:20] = imm[4:0];
                    legal           = (imm < 32'd32);
                end else begin
                    imm_bits[31:20] = imm[11:0];
                    legal           = in_range(imm, -2048, 2047);
                end
            end
            I_LOAD, JALR: begin
                imm_bits[31:20] = imm[11:0];
                legal           = in_range(imm, -2048, 2047);
            end
            S: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
                legal           = in_range(imm, -2048, 2047);
            end
            B: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
                legal           = !imm[0] && in_range(imm, -4096, 4094);
            end
            U_LUI, U_AUIPC: begin
                imm_bits[31:12] = imm[31:12];
                legal           = (imm[11:0] == 12'h000);
            end
            default: begin // JAL
                imm_bits[31:12] = {imm[20], imm[10:1], imm[11], imm[19:12]};
                legal           = !imm[0] && in_range(imm, -1048576, 1048574);
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: one registered output stage with
// valid/ready on both sides, address tagging and an error counter.
module instr_encoder
    import enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = DEF_NOP_WORD
) (
    input  logic            clk_i,
    input  logic            rst_i,
    instr_encoder_if.slave  bus
);

    logic [31:0] imm_bits;
    logic        imm_legal;
    logic [31:0] word;
    enc_beat_t   beat_d;
    enc_beat_t   beat_q;
    logic        valid_q;
    logic [31:0] addr_q;
    logic [15:0] cnt_q;
    logic        accept;
    logic        deliver;

    imm_pack u_imm_pack (
        .fmt      (bus.fmt_i),
        .funct3   (bus.funct3_i),
        .funct7   (bus.funct7_i),
        .imm      (bus.imm_i),
        .imm_bits (imm_bits),
        .legal    (imm_legal)
    );

    // Merge register fields and opcode around the placed immediate
    always_comb begin
        word      = imm_bits;
        word[6:0] = opcode_of(bus.fmt_i);
        case (bus.fmt_i)
            I_CALC, I_LOAD, JALR: begin
                word[11:7]  = bus.rd_i;
                word[14:12] = bus.funct3_i;
                word[19:15] = bus.rs1_i;
            end
            S, B: begin
                word[14:12] = bus.funct3_i;
                word[19:15] = bus.rs1_i;
                word[24:20] = bus.rs2_i;
            end
            default: begin // U_LUI, U_AUIPC, JAL
                word[11:7]  = bus.rd_i;
            end
        endcase
    end

    // Unencodable immediates are replaced by a NOP and flagged
    always_comb begin
        beat_d.instr = imm_legal ? word : NOP_WORD;
        beat_d.err   = !imm_legal;
    end

    assign bus.ready_o = !valid_q || bus.ready_i;
    assign accept      = bus.valid_i && bus.ready_o;
    assign deliver     = valid_q && bus.ready_i;

    // Output stage, delivery address and saturating error count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
            addr_q  <= BASE_ADDR;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                valid_q <= 1'b1;
                beat_q  <= beat_d;
            end else if (deliver) begin
                valid_q <= 1'b0;
            end
            // addr_q always tags the beat at the head of the output stage
            if (deliver) begin
                addr_q <= addr_q + 32'd4;
                if (beat_q.err && (cnt_q != 16'hFFFF))
                    cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.valid_o   = valid_q;
    assign bus.instr_o   = beat_q.instr;
    assign bus.err_o     = beat_q.err;
    assign bus.addr_o    = addr_q;
    assign bus.err_cnt_o = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed encodings, immediate
// boundaries, backpressure, mid-stream reset and random legal beats.
module tb_instr_encoder;
    import enc_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_encoder_if bus ();

    instr_encoder #(.BASE_ADDR(BASE), .NOP_WORD(NOP)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        fmt_e        fmt;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        err;
        logic        exact;
        logic [31:0] word;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr;
    logic [15:0] exp_cnt;

    function automatic exp_t mk(fmt_e f, int rd, int rs1, int rs2, int f3, int f7,
                                int imm, bit err, bit exact, logic [31:0] word);
        exp_t e;
        e.fmt = f; e.rd = 5'(rd); e.rs1 = 5'(rs1); e.rs2 = 5'(rs2);
        e.f3 = 3'(f3); e.f7 = 7'(f7); e.imm = 32'(imm);
        e.err = err; e.exact = exact; e.word = word;
        return e;
    endfunction

    function automatic logic [6:0] ref_op(fmt_e f);
        case (f)
            I_CALC:  return 7'h13;
            I_LOAD:  return 7'h03;
            S:       return 7'h23;
            B:       return 7'h63;
            U_LUI:   return 7'h37;
            U_AUIPC: return 7'h17;
            JAL:     return 7'h6F;
            default: return 7'h67;
        endcase
    endfunction

    // Reference immediate generator (decoder side)
    function automatic logic [31:0] dec_imm(fmt_e f, logic [2:0] f3, logic [31:0] w);
        case (f)
            I_CALC:         return (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, w[24:20]}
                                                              : {{20{w[31]}}, w[31:20]};
            I_LOAD, JALR:   return {{20{w[31]}}, w[31:20]};
            S:              return {{20{w[31]}}, w[31:25], w[11:7]};
            B:              return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            U_LUI, U_AUIPC: return {w[31:12], 12'h000};
            default:        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    function automatic bit fields_ok(exp_t e, logic [31:0] w);
        bit ok;
        ok = (w[6:0] == ref_op(e.fmt));
        case (e.fmt)
            I_CALC, I_LOAD, JALR: begin
                ok &= (w[11:7] == e.rd) && (w[19:15] == e.rs1) && (w[14:12] == e.f3);
                if (e.fmt == I_CALC && (e.f3 == 3'd1 || e.f3 == 3'd5))
                    ok &= (w[31:25] == e.f7);
            end
            S, B:    ok &= (w[24:20] == e.rs2) && (w[19:15] == e.rs1) && (w[14:12] == e.f3);
            default: ok &= (w[11:7] == e.rd);
        endcase
        return ok;
    endfunction

    function automatic exp_t rand_beat();
        exp_t e;
        int   im;
        logic [31:0] r;
        e = mk(fmt_e'($urandom_range(0, 7)), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 7), 0, 0, 0, 0, 32'h0);
        case (e.fmt)
            I_CALC: begin
                if (e.f3 == 3'd1 || e.f3 == 3'd5) begin
                    im   = $urandom_range(0, 31);
                    e.f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
                end else im = int'($urandom_range(0, 4095)) - 2048;
            end
            I_LOAD, JALR, S: im = int'($urandom_range(0, 4095)) - 2048;
            B:               im = (int'($urandom_range(0, 4095)) - 2048) * 2;
            U_LUI, U_AUIPC: begin
                r = $urandom; r[11:0] = 12'h000; im = int'(r);
            end
            default:         im = (int'($urandom_range(0, 1048575)) - 524288) * 2;
        endcase
        e.imm = 32'(im);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input exp_t e);
        bus.valid_i  = 1'b1;
        bus.fmt_i    = e.fmt;
        bus.rd_i     = e.rd;
        bus.rs1_i    = e.rs1;
        bus.rs2_i    = e.rs2;
        bus.funct3_i = e.f3;
        bus.funct7_i = e.f7;
        bus.imm_i    = e.imm;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ready_i = 1'b1;
        drive(mk(I_CALC, 3, 3, 0, 0, 0, 7, 0, 1, 32'h0));
        tick();
        tick();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        checks++; if (bus.instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", bus.instr_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
        checks++; if (bus.addr_o !== BASE) begin errors++; $display("FAIL reset_addr: got %h want %h", bus.addr_o, BASE); end
        checks++; if (bus.err_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", bus.err_cnt_o); end
        rst = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        #1;
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
        exp_addr = BASE;
        exp_cnt  = 16'h0;
        sb.delete();
    endtask

    task automatic test_directed();
        exp_t tbl[$];
        exp_t e;
        int   n = 0;
        int   cyc = 0;
        tbl.push_back(mk(I_CALC, 1, 0, 0, 0, 0, 5, 0, 1, 32'h0050_0093));
        tbl.push_back(mk(B, 0, 1, 2, 1, 0, -4, 0, 1, 32'hFE20_9EE3));
        tbl.push_back(mk(B, 0, 1, 2, 1, 0, 3, 1, 0, 32'h0));
        tbl.push_back(mk(JAL, 1, 0, 0, 0, 0, 2048, 0, 1, 32'h0010_00EF));
        tbl.push_back(mk(U_LUI, 1, 0, 0, 0, 0, 32'h1234_5001, 1, 0, 32'h0));
        tbl.push_back(mk(U_LUI, 5, 0, 0, 0, 0, 32'h1234_5000, 0, 1, 32'h1234_52B7));
        tbl.push_back(mk(I_CALC, 2, 3, 0, 0, 0, 2047, 0, 0, 32'h0));
        tbl.push_back(mk(I_CALC, 2, 3, 0, 0, 0, 2048, 1, 0, 32'h0));
        tbl.push_back(mk(I_LOAD, 4, 5, 0, 2, 0, -2048, 0, 0, 32'h0));
        tbl.push_back(mk(JALR, 4, 5, 0, 0, 0, -2049, 1, 0, 32'h0));
        tbl.push_back(mk(I_CALC, 6, 7, 0, 1, 0, 31, 0, 0, 32'h0));
        tbl.push_back(mk(I_CALC, 6, 7, 0, 5, 32, 32, 1, 0, 32'h0));
        tbl.push_back(mk(I_CALC, 6, 7, 0, 5, 32, 7, 0, 0, 32'h0));
        tbl.push_back(mk(S, 9, 8, 10, 2, 0, 2047, 0, 0, 32'h0));
        tbl.push_back(mk(S, 9, 8, 10, 2, 0, -2049, 1, 0, 32'h0));
        tbl.push_back(mk(B, 9, 11, 12, 0, 0, 4094, 0, 0, 32'h0));
        tbl.push_back(mk(B, 9, 11, 12, 0, 0, 4096, 1, 0, 32'h0));
        tbl.push_back(mk(B, 9, 11, 12, 0, 0, -4096, 0, 0, 32'h0));
        tbl.push_back(mk(B, 9, 11, 12, 0, 0, -4098, 1, 0, 32'h0));
        tbl.push_back(mk(JAL, 13, 1, 1, 0, 0, 1048574, 0, 0, 32'h0));
        tbl.push_back(mk(JAL, 13, 1, 1, 0, 0, 1048576, 1, 0, 32'h0));
        tbl.push_back(mk(JAL, 13, 1, 1, 0, 0, -1048576, 0, 0, 32'h0));
        tbl.push_back(mk(JAL, 13, 1, 1, 0, 0, 5, 1, 0, 32'h0));
        tbl.push_back(mk(U_AUIPC, 14, 1, 1, 0, 0, 32'hFFFF_F000, 0, 0, 32'h0));
        tbl.push_back(mk(U_AUIPC, 14, 1, 1, 0, 0, 32'h0000_0800, 1, 0, 32'h0));
        bus.ready_i = 1'b1;
        while ((n < tbl.size() || sb.size() != 0) && cyc < 200) begin
            if (n < tbl.size()) drive(tbl[n]); else bus.valid_i = 1'b0;
            #1;
            if (bus.valid_o && bus.ready_i) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL dir_unexpected: got beat %h want none", bus.instr_o); end
                else begin
                    e = sb.pop_front();
                    checks++; if (bus.addr_o !== exp_addr) begin errors++; $display("FAIL dir_addr: got %h want %h", bus.addr_o, exp_addr); end
                    checks++; if (bus.err_o !== e.err) begin errors++; $display("FAIL dir_err: got %b want %b imm %h", bus.err_o, e.err, e.imm); end
                    checks++; if (bus.err_cnt_o !== exp_cnt) begin errors++; $display("FAIL dir_cnt: got %0d want %0d", bus.err_cnt_o, exp_cnt); end
                    if (e.err || e.exact) begin
                        checks++;
                        if (bus.instr_o !== (e.err ? NOP : e.word)) begin errors++; $display("FAIL dir_word: got %h want %h", bus.instr_o, e.err ? NOP : e.word); end
                    end else begin
                        checks++; if (dec_imm(e.fmt, e.f3, bus.instr_o) !== e.imm) begin errors++; $display("FAIL dir_imm: got %h want %h", dec_imm(e.fmt, e.f3, bus.instr_o), e.imm); end
                        checks++; if (!fields_ok(e, bus.instr_o)) begin errors++; $display("FAIL dir_fields: got %h fmt %0d", bus.instr_o, e.fmt); end
                    end
                    exp_addr += 32'd4;
                    if (e.err && exp_cnt != 16'hFFFF) exp_cnt++;
                end
            end
            if (bus.valid_i && bus.ready_o) begin sb.push_back(tbl[n]); n++; end
            tick();
            cyc++;
        end
        checks++; if (cyc >= 200) begin errors++; $display("FAIL dir_timeout: got %0d cycles want < 200", cyc); end
        bus.valid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.ready_i = 1'b0;
        drive(mk(I_CALC, 1, 0, 0, 0, 0, 1, 0, 1, 32'h0));
        tick();
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL mid_held: got %b want 1", bus.valid_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", bus.valid_o); end
        checks++; if (bus.addr_o !== BASE) begin errors++; $display("FAIL mid_addr: got %h want %h", bus.addr_o, BASE); end
        checks++; if (bus.err_cnt_o !== 16'h0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", bus.err_cnt_o); end
        exp_addr = BASE;
        exp_cnt  = 16'h0;
        sb.delete();
    endtask

    task automatic test_back_to_back();
        exp_t b[4];
        exp_t e;
        for (int k = 0; k < 4; k++)
            b[k] = mk(I_CALC, k + 1, 0, 0, 0, 0, k + 1, 0, 1,
                      (32'(k + 1) << 20) | (32'(k + 1) << 7) | 32'h13);
        bus.ready_i = 1'b1;
        drive(b[0]);
        #1;
        if (bus.valid_i && bus.ready_o) sb.push_back(b[0]);
        tick();
        e = sb.pop_front();
        checks++; if (bus.valid_o !== 1'b1 || bus.instr_o !== e.word) begin errors++; $display("FAIL b2b_first: got %b/%h want 1/%h", bus.valid_o, bus.instr_o, e.word); end
        checks++; if (bus.addr_o !== exp_addr) begin errors++; $display("FAIL b2b_addr0: got %h want %h", bus.addr_o, exp_addr); end
        bus.ready_i = 1'b0;
        drive(b[1]);
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b want 0", bus.ready_o); end
            tick();
            checks++;
            if (bus.valid_o !== 1'b1 || bus.instr_o !== e.word || bus.addr_o !== exp_addr)
            begin errors++; $display("FAIL b2b_hold: got %b/%h/%h want 1/%h/%h", bus.valid_o, bus.instr_o, bus.addr_o, e.word, exp_addr); end
        end
        for (int k = 1; k < 4; k++) begin
            bus.ready_i = 1'b1;
            drive(b[k]);
            #1;
            if (bus.valid_i && bus.ready_o) sb.push_back(b[k]);
            exp_addr += 32'd4;
            tick();
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL b2b_lost: got no beat want beat %0d", k); end
            else begin
                e = sb.pop_front();
                checks++; if (bus.instr_o !== e.word) begin errors++; $display("FAIL b2b_word: got %h want %h", bus.instr_o, e.word); end
                checks++; if (bus.addr_o !== exp_addr) begin errors++; $display("FAIL b2b_addr: got %h want %h", bus.addr_o, exp_addr); end
            end
        end
        bus.valid_i = 1'b0;
        #1;
        exp_addr += 32'd4;
        tick();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", bus.valid_o); end
        checks++; if (bus.addr_o !== exp_addr) begin errors++; $display("FAIL b2b_next_addr: got %h want %h", bus.addr_o, exp_addr); end
    endtask

    task automatic test_random();
        exp_t cur;
        exp_t e;
        bit   pending = 0;
        int   n = 0;
        int   cyc = 0;
        while ((n < 60 || pending || sb.size() != 0) && cyc < 2000) begin
            if (!pending && n < 60 && $urandom_range(0, 3) != 0) begin
                cur = rand_beat();
                pending = 1;
            end
            if (pending) drive(cur); else bus.valid_i = 1'b0;
            bus.ready_i = ($urandom_range(0, 9) < 7);
            #1;
            if (bus.valid_o && bus.ready_i) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL rnd_unexpected: got beat %h want none", bus.instr_o); end
                else begin
                    e = sb.pop_front();
                    checks++; if (bus.addr_o !== exp_addr) begin errors++; $display("FAIL rnd_addr: got %h want %h", bus.addr_o, exp_addr); end
                    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rnd_err: got %b want 0 fmt %0d imm %h", bus.err_o, e.fmt, e.imm); end
                    checks++; if (dec_imm(e.fmt, e.f3, bus.instr_o) !== e.imm) begin errors++; $display("FAIL rnd_imm: got %h want %h fmt %0d", dec_imm(e.fmt, e.f3, bus.instr_o), e.imm, e.fmt); end
                    checks++; if (!fields_ok(e, bus.instr_o)) begin errors++; $display("FAIL rnd_fields: got %h fmt %0d", bus.instr_o, e.fmt); end
                    exp_addr += 32'd4;
                end
            end
            if (bus.valid_i && bus.ready_o) begin sb.push_back(cur); pending = 0; n++; end
            tick();
            cyc++;
        end
        checks++; if (cyc >= 2000) begin errors++; $display("FAIL rnd_timeout: got %0d cycles want < 2000", cyc); end
        checks++; if (bus.err_cnt_o !== exp_cnt) begin errors++; $display("FAIL rnd_cnt: got %0d want %0d", bus.err_cnt_o, exp_cnt); end
        bus.valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
